// File: rtl/chan_tx_stream_arb.sv
// chan_tx_stream_arb: packet-aware round-robin arbiter that merges NUM_SRC
// beat streams onto one registered chan_tx output stage. Whole packets are
// granted, so packets from different sources never interleave, and a
// per-source statistic pulse is raised when each EOP beat is accepted.
// Optional feature: define CHAN_TX_ARB_WDOG_EN to close any packet that
// reaches MAX_PKT_BEATS beats without EOP (forced EOP plus ostat_err pulse).
module chan_tx_stream_arb #(
    parameter int NUM_SRC       = 2,
    parameter int DW            = 128,
    parameter int EXW           = 16,
    parameter int MAX_PKT_BEATS = 64
) (
    input  logic                   sys_clk,
    input  logic                   sys_rst_n,
    input  logic [NUM_SRC*EXW-1:0] src_data_ex,
    input  logic [NUM_SRC*DW-1:0]  src_data,
    input  logic [NUM_SRC-1:0]     src_wen,
    output logic [NUM_SRC-1:0]     src_ready,
    output logic [EXW-1:0]         out_data_ex,
    output logic [DW-1:0]          out_data,
    output logic                   out_wen,
    input  logic                   out_ready,
    output logic [NUM_SRC-1:0]     ostat_inc,
    output logic                   ostat_err
);

    localparam int PW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
    localparam logic [PW-1:0] LAST_SRC = PW'(NUM_SRC - 1);
    localparam logic [PW:0]   NUM_SRC_W = (PW+1)'(NUM_SRC);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    state_e               state_q, state_d;
    logic [PW-1:0]        grant_q, grant_d;
    logic [PW-1:0]        rr_ptr_q, rr_ptr_d;
    logic                 out_wen_q, out_wen_d;
    logic [DW-1:0]        out_data_q, out_data_d;
    logic [EXW-1:0]       out_ex_q, out_ex_d;
    logic [NUM_SRC-1:0]   ostat_inc_q, ostat_inc_d;
    logic                 ostat_err_q, ostat_err_d;

    logic                 can_load;
    logic                 beat_acc;
    logic                 beat_eop;
    logic                 wdog_hit;
    logic                 found;
    logic [PW-1:0]        pick;
    logic [PW:0]          search_idx;
    logic [PW-1:0]        grant_nxt;
    logic [DW-1:0]        sel_data;
    logic [EXW-1:0]       sel_ex;

    // Granted source's beat, per-source ready and the accept qualifier
    always_comb begin
        // NOTE: every combinational output gets a default first, so no path leaves it unassigned and no latch is inferred.
        src_ready = '0;
        can_load  = !out_wen_q || out_ready;
        sel_data  = src_data[grant_q*DW +: DW];
        sel_ex    = src_data_ex[grant_q*EXW +: EXW];
        for (int i = 0; i < NUM_SRC; i++) begin
            src_ready[i] = (state_q == BUSY) && (grant_q == PW'(i)) && can_load;
        end
        beat_acc  = (state_q == BUSY) && can_load && src_wen[grant_q];
        beat_eop  = sel_ex[1];
        grant_nxt = (grant_q == LAST_SRC) ? '0 : grant_q + PW'(1);
    end

    // Rotating search from rr_ptr upward; descending scan so the smallest offset wins
    always_comb begin
        found      = 1'b0;
        pick       = rr_ptr_q;
        search_idx = '0;
        for (int k = NUM_SRC - 1; k >= 0; k--) begin
            search_idx = {1'b0, rr_ptr_q} + (PW+1)'(k);
            if (search_idx >= NUM_SRC_W) begin
                search_idx = search_idx - NUM_SRC_W;
            end
            if (src_wen[search_idx[PW-1:0]]) begin
                found = 1'b1;
                pick  = search_idx[PW-1:0];
            end
        end
    end

`ifdef CHAN_TX_ARB_WDOG_EN
    localparam int BCW = $clog2(MAX_PKT_BEATS + 1);
    logic [BCW-1:0] beat_cnt_q, beat_cnt_d;

    // Beat counter: cleared on grant, counts accepted beats, trips at the limit
    always_comb begin
        beat_cnt_d = beat_cnt_q;
        if (state_q == IDLE && found) begin
            beat_cnt_d = '0;
        end else if (beat_acc) begin
            beat_cnt_d = beat_cnt_q + BCW'(1);
        end
        wdog_hit = beat_acc && !beat_eop && (beat_cnt_q == BCW'(MAX_PKT_BEATS - 1));
    end

    // Beat counter register
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            beat_cnt_q <= '0;
        end else begin
            beat_cnt_q <= beat_cnt_d;
        end
    end
`else
    // No watchdog: a grant is held until the source delivers EOP
    always_comb begin
        wdog_hit = 1'b0;
    end
`endif

    // FSM next state, output-stage load and statistic pulses
    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        rr_ptr_d    = rr_ptr_q;
        out_wen_d   = out_wen_q && !out_ready;
        out_data_d  = out_data_q;
        out_ex_d    = out_ex_q;
        ostat_inc_d = '0;
        ostat_err_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (found) begin
                    grant_d = pick;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (beat_acc) begin
                    out_wen_d  = 1'b1;
                    out_data_d = sel_data;
                    out_ex_d   = sel_ex;
                    if (wdog_hit) begin
                        out_ex_d[1] = 1'b1;
                    end
                    if (beat_eop || wdog_hit) begin
                        state_d              = IDLE;
                        rr_ptr_d             = grant_nxt;
                        ostat_inc_d[grant_q] = beat_eop;
                        ostat_err_d          = wdog_hit;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers; reset drops any partial packet at once
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!sys_rst_n) begin
            state_q     <= IDLE;
            grant_q     <= '0;
            rr_ptr_q    <= '0;
            out_wen_q   <= 1'b0;
            out_data_q  <= '0;
            out_ex_q    <= '0;
            ostat_inc_q <= '0;
            ostat_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            rr_ptr_q    <= rr_ptr_d;
            out_wen_q   <= out_wen_d;
            out_data_q  <= out_data_d;
            out_ex_q    <= out_ex_d;
            ostat_inc_q <= ostat_inc_d;
            ostat_err_q <= ostat_err_d;
        end
    end

    assign out_wen     = out_wen_q;
    assign out_data    = out_data_q;
    assign out_data_ex = out_ex_q;
    assign ostat_inc   = ostat_inc_q;
    assign ostat_err   = ostat_err_q;

endmodule
